// File: rtl/fir_error_monitor.sv
// fir_error_monitor
// Runtime accuracy monitor for the approximate shift-coefficient FIR. It
// recomputes the exact 5-tap response from the same input stream and
// accumulates error statistics over a window of 2^WIN_LOG2 valid samples.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      one-cycle pulse, begins a measurement window (ignored while busy)
//   x_in       sample driven into the filter this cycle
//   x_valid    qualifies x_in / approx_in for statistics
//   approx_in  filter output for the same cycle as x_in
//   busy       measurement in progress
//   done       one-cycle pulse, statistics final
//   err_cnt    number of samples with nonzero error
//   max_err    largest absolute error seen
//   sum_err    saturating sum of absolute errors
//   mismatch   registered nonzero-error flag for the sample in S2
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; statistics hold
// PRIME | 4 cycles letting the delay line fill with post-start samples
// RUN   | counting valid samples until the window is complete
// DRAIN | 2 cycles flushing the S2/S3 pipeline
// DONE  | done pulse, statistics final
module fir_error_monitor #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 10,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    x_in,
  input  logic                x_valid,
  input  logic [WIDTH-1:0]    approx_in,
  output logic                busy,
  output logic                done,
  output logic [WIN_LOG2:0]   err_cnt,
  output logic [WIDTH-1:0]    max_err,
  output logic [ACC_W-1:0]    sum_err,
  output logic                mismatch
);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [WIN_LOG2:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};

  state_t            state, state_nxt;
  logic [1:0]        tmr, tmr_nxt;
  logic [WIN_LOG2:0] remain, remain_nxt;
  logic              clr_stats;

  logic [WIDTH-1:0]  d1, d2, d3, d4;
  logic [WIDTH-1:0]  exact;
  logic [WIDTH-1:0]  s1_exact, s1_approx;
  logic              s1_valid;
  logic [WIDTH:0]    diff, neg_diff;
  logic [WIDTH-1:0]  abs_err;
  logic [WIDTH-1:0]  s2_err;
  logic              s2_valid;
  logic [ACC_W:0]    sum_ext;

  // Exact reference: truncating logical shifts, sum wraps like the filter.
  always_comb begin
    exact = (x_in >> 5) + (d1 >> 4) + (d2 >> 3) + (d3 >> 2) + (d4 >> 1);
  end

  always_comb begin
    diff     = {1'b0, s1_exact} - {1'b0, s1_approx};
    neg_diff = -diff;
    // Magnitude never exceeds 2^WIDTH-1, so the low WIDTH bits are exact.
    abs_err  = diff[WIDTH] ? neg_diff[WIDTH-1:0] : diff[WIDTH-1:0];
    sum_ext  = {1'b0, sum_err} + {{(ACC_W + 1 - WIDTH){1'b0}}, s2_err};
  end

  // Window length is a down-counter of remaining valid samples; PRIME and
  // DRAIN share one small down-counter.
  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    remain_nxt = remain;
    clr_stats  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          clr_stats  = 1'b1;
          tmr_nxt    = 2'd3;
          remain_nxt = WIN_LEN;
          state_nxt  = S_PRIME;
        end
      end
      S_PRIME: begin
        if (tmr == 2'd0) state_nxt = S_RUN;
        else             tmr_nxt   = tmr - 2'd1;
      end
      S_RUN: begin
        if (x_valid) begin
          remain_nxt = remain - 1'b1;
          if (remain == {{WIN_LOG2{1'b0}}, 1'b1}) begin
            tmr_nxt   = 2'd1;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (tmr == 2'd0) state_nxt = S_DONE;
        else             tmr_nxt   = tmr - 2'd1;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      remain    <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      d4        <= '0;
      s1_exact  <= '0;
      s1_approx <= '0;
      s1_valid  <= 1'b0;
      s2_err    <= '0;
      s2_valid  <= 1'b0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      max_err   <= '0;
      sum_err   <= '0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      remain    <= remain_nxt;
      // Free-running taps, mirroring the filter regardless of x_valid.
      d1        <= x_in;
      d2        <= d1;
      d3        <= d2;
      d4        <= d3;
      s1_exact  <= exact;
      s1_approx <= approx_in;
      s1_valid  <= x_valid && (state == S_RUN);
      s2_err    <= abs_err;
      s2_valid  <= s1_valid;
      mismatch  <= |abs_err;
      if (clr_stats) begin
        err_cnt <= '0;
        max_err <= '0;
        sum_err <= '0;
      end else if (s2_valid) begin
        err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, |s2_err};
        if (s2_err > max_err) max_err <= s2_err;
        sum_err <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      end
    end
  end

endmodule
